// File: rtl/arm_mc_controller.sv
// ============================================================================
// Module      : arm_mc_controller
// Description : Multicycle control FSM for the ARM subset core, with NZCV flag
//               register, condition evaluation and memory-ready stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_mc_controller #(
    parameter bit USE_MEMREADY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] r_flags;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_unused_rn;
    logic       w_ready;
    logic       w_condex;
    logic       w_n, w_z, w_c, w_v;

    logic [1:0] w_alu_ctl;
    logic       w_nowrite;
    logic       w_is_mov;
    logic       w_arith;

    logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_funct     = Instr[13:8];
    assign w_rd        = Instr[3:0];
    assign w_unused_rn = ^Instr[7:4];
    assign w_ready     = USE_MEMREADY ? MemReady : 1'b1;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~(w_c & ~w_z);
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = ~(~w_z & (w_n == w_v));
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // Data-processing decode; C,V are only meaningful for arithmetic ops
    always_comb begin
        w_alu_ctl = 2'b00;
        w_nowrite = 1'b0;
        w_is_mov  = 1'b0;
        w_arith   = 1'b0;
        case (w_funct[4:1])
            4'b0100: w_arith = 1'b1;
            4'b0010: begin w_alu_ctl = 2'b01; w_arith = 1'b1; end
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            4'b1101: w_is_mov = 1'b1;
            4'b1010: begin w_alu_ctl = 2'b01; w_nowrite = 1'b1; w_arith = 1'b1; end
            4'b1000: begin w_alu_ctl = 2'b10; w_nowrite = 1'b1; end
            default: w_nowrite = 1'b1;
        endcase
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:    w_next = w_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                if (!w_condex)          w_next = c_FETCH;
                else if (w_op == 2'b00) w_next = w_funct[5] ? c_EXECUTEI : c_EXECUTER;
                else if (w_op == 2'b01) w_next = c_MEMADR;
                else if (w_op == 2'b10) w_next = c_BRANCH;
                else                    w_next = c_FETCH;
            end
            c_MEMADR:   w_next = w_funct[0] ? c_MEMREAD : c_MEMWRITE;
            c_MEMREAD:  w_next = w_ready ? c_MEMWB : c_MEMREAD;
            c_MEMWRITE: w_next = w_ready ? c_FETCH : c_MEMWRITE;
            c_EXECUTER,
            c_EXECUTEI: w_next = c_ALUWB;
            default:    w_next = c_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        AdrSrc     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        w_regwrite = 1'b0;
        case (r_state)
            c_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
            end
            c_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
            end
            c_MEMREAD: AdrSrc = 1'b1;
            c_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_pcwrite  = (w_rd == 4'd15);
            end
            c_MEMWRITE: begin
                AdrSrc     = 1'b1;
                RegSrc     = 2'b10;
                w_memwrite = 1'b1;
            end
            c_EXECUTER,
            c_EXECUTEI: begin
                ALUSrcA    = w_is_mov ? 2'b10 : 2'b00;
                ALUSrcB    = (r_state == c_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = w_alu_ctl;
            end
            c_ALUWB: begin
                w_regwrite = ~w_nowrite;
                w_pcwrite  = ~w_nowrite & (w_rd == 4'd15);
            end
            c_BRANCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes must drop the moment reset asserts, not at the next edge
    assign PCWrite  = w_pcwrite  & reset;
    assign MemWrite = w_memwrite & reset;
    assign IRWrite  = w_irwrite  & reset;
    assign RegWrite = w_regwrite & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (((r_state == c_EXECUTER) || (r_state == c_EXECUTEI)) && w_funct[0]) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_arith)
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign Flags = r_flags;
    assign State = r_state;

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
// ============================================================================
// Module      : tb_arm_mc_controller
// Description : Directed self-checking bench for arm_mc_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_mc_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags, State;

    int n_checks = 0;
    int n_pass   = 0;

    arm_mc_controller #(.USE_MEMREADY(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .Flags      (Flags),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One controller cycle: inputs change on the falling edge, outputs sampled 1ns later
    task automatic cyc(input logic rdy, input logic [3:0] af);
        @(negedge clk);
        MemReady = rdy;
        ALUFlags = af;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        MemReady = 1'b1;
        #1;
        check("rst_state", State, 0);
        check("rst_flags", Flags, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);

        // ADD R2,R0,#5
        @(negedge clk);
        reset = 1'b1;
        Instr = 20'hE2802;
        #1;
        check("add_s0", State, 0);
        check("add_irw0", IRWrite, 1);
        check("add_pcw0", PCWrite, 1);
        check("add_srcb0", ALUSrcB, 2'b10);
        cyc(1, 4'h0);
        check("add_s1", State, 1);
        check("add_irw1", IRWrite, 0);
        cyc(1, 4'h0);
        check("add_s2", State, 7);
        check("add_srcb2", ALUSrcB, 2'b01);
        check("add_rw2", RegWrite, 0);
        cyc(1, 4'h0);
        check("add_s3", State, 8);
        check("add_rw3", RegWrite, 1);
        check("add_pcw3", PCWrite, 0);
        cyc(1, 4'h0);
        check("add_s4", State, 0);
        check("add_flags", Flags, 0);

        // CMP R1,R1 sets Z and C
        Instr = 20'hE1510;
        cyc(1, 4'h0);
        check("cmp_s1", State, 1);
        cyc(1, 4'b0110);
        check("cmp_s2", State, 6);
        check("cmp_aluctl", ALUControl, 2'b01);
        check("cmp_rw2", RegWrite, 0);
        cyc(1, 4'h0);
        check("cmp_s3", State, 8);
        check("cmp_rw3", RegWrite, 0);
        check("cmp_flags", Flags, 4'b0110);
        cyc(1, 4'h0);
        check("cmp_s4", State, 0);

        // BEQ taken
        Instr = 20'h0A000;
        cyc(1, 4'h0);
        check("beq_s1", State, 1);
        cyc(1, 4'h0);
        check("beq_s2", State, 9);
        check("beq_pcw", PCWrite, 1);
        check("beq_imm", ImmSrc, 2'b10);
        cyc(1, 4'h0);
        check("beq_s3", State, 0);

        // BNE squashed
        Instr = 20'h1A000;
        cyc(1, 4'h0);
        check("bne_s1", State, 1);
        check("bne_pcw1", PCWrite, 0);
        cyc(1, 4'h0);
        check("bne_s2", State, 0);

        // LDR with two wait cycles in MEMREAD
        Instr = 20'hE5902;
        cyc(1, 4'h0);
        check("ldr_s1", State, 1);
        cyc(1, 4'h0);
        check("ldr_s2", State, 2);
        check("ldr_imm", ImmSrc, 2'b01);
        cyc(0, 4'h0);
        check("ldr_s3a", State, 3);
        check("ldr_adr_a", AdrSrc, 1);
        cyc(0, 4'h0);
        check("ldr_s3b", State, 3);
        check("ldr_adr_b", AdrSrc, 1);
        cyc(1, 4'h0);
        check("ldr_s3c", State, 3);
        check("ldr_adr_c", AdrSrc, 1);
        cyc(1, 4'h0);
        check("ldr_s4", State, 4);
        check("ldr_rw", RegWrite, 1);
        check("ldr_res", ResultSrc, 2'b01);
        cyc(1, 4'h0);
        check("ldr_s5", State, 0);

        // STR with one wait cycle
        Instr = 20'hE5802;
        cyc(1, 4'h0);
        cyc(1, 4'h0);
        check("str_s2", State, 2);
        cyc(0, 4'h0);
        check("str_s3", State, 5);
        check("str_mw_a", MemWrite, 1);
        check("str_regsrc", RegSrc, 2'b10);
        cyc(1, 4'h0);
        check("str_s4", State, 5);
        check("str_mw_b", MemWrite, 1);
        check("str_rw", RegWrite, 0);
        cyc(1, 4'h0);
        check("str_s5", State, 0);
        check("str_mw_c", MemWrite, 0);

        // STRNE with Z=1 squashed
        Instr = 20'h15802;
        cyc(1, 4'h0);
        check("strne_s1", State, 1);
        check("strne_mw", MemWrite, 0);
        cyc(1, 4'h0);
        check("strne_s2", State, 0);

        // MOV R3,R10
        Instr = 20'hE1A03;
        cyc(1, 4'h0);
        cyc(1, 4'h0);
        check("mov_s2", State, 6);
        check("mov_srca", ALUSrcA, 2'b10);
        check("mov_srcb", ALUSrcB, 2'b00);
        cyc(1, 4'h0);
        check("mov_rw", RegWrite, 1);
        cyc(1, 4'h0);

        // MOVS R0,#15: only N,Z captured
        Instr = 20'hE3B00;
        cyc(1, 4'h0);
        cyc(1, 4'b1011);
        check("movs_s2", State, 7);
        cyc(1, 4'h0);
        check("movs_flags", Flags, 4'b1010);
        cyc(1, 4'h0);
        check("movs_s4", State, 0);

        // Reset asserted in MEMWRITE while stalled
        Instr = 20'hE5802;
        cyc(1, 4'h0);
        cyc(1, 4'h0);
        cyc(0, 4'h0);
        check("abort_pre", MemWrite, 1);
        reset = 1'b0;
        #1;
        check("abort_mw", MemWrite, 0);
        check("abort_state", State, 0);
        check("abort_flags", Flags, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM subset core (ADD, SUB, AND, ORR, MOV, CMP, TST, LDR, STR, B). It sequences a shared-memory multicycle datapath through a main state machine, one instruction at a time. It holds the NZCV status flags and evaluates condition codes. It stalls on a memory-ready handshake, so the single memory port can be shared between instruction fetch and data access.

## Interface
Parameters:
- USE_MEMREADY, default 1: 1 = FETCH/MEMREAD/MEMWRITE wait for MemReady; 0 = MemReady ignored, treated as 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- Instr  in  20  instruction register bits [31:12] (Cond, Op, Funct, Rd)
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
- ALUSrcA  out  2  00 = Rn (A register), 01 = PC, 10 = zero
- ALUSrcB  out  2  00 = Rm (WriteData), 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24
- RegSrc  out  2  [0] RA1 = R15; [1] RA2 = Rd
- RegWrite  out  1  register file write
- Flags  out  4  registered {N,Z,C,V}
- State  out  4  current state, debug

## Operation
- State encoding:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMREAD = 3
  - MEMWB = 4
  - MEMWRITE = 5
  - EXECUTER = 6
  - EXECUTEI = 7
  - ALUWB = 8
  - BRANCH = 9
  - Unused codes go to FETCH on the next edge.
- FETCH:
  - Drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Advance to DECODE only when MemReady=1; otherwise hold.
- DECODE:
  - Drive ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, which forms PC+8 for R15 reads.
  - Evaluate CondEx from Cond and the registered Flags (EQ..LE, AL; Cond=1111 treated as false).
  - If CondEx=0, next state is FETCH (instruction squashed, no writes).
  - Op=00: Funct[5]=1 goes to EXECUTEI, Funct[5]=0 goes to EXECUTER.
  - Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 goes to FETCH.
- MEMADR:
  - Drive ALUSrcA=00, ALUSrcB=01, ImmSrc=01, ADD.
  - Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD:
  - Drive AdrSrc=1.
  - Go to MEMWB when MemReady=1; otherwise hold.
- MEMWB:
  - Drive ResultSrc=01, RegWrite=1.
  - PCWrite=1 if Rd=15.
  - Next state: FETCH.
- MEMWRITE:
  - Drive AdrSrc=1, RegSrc[1]=1, MemWrite=1 every cycle in this state.
  - Go to FETCH when MemReady=1.
- EXECUTER / EXECUTEI:
  - ALUSrcB = 00 (EXECUTER) or 01 (EXECUTEI), ImmSrc=00.
  - ALU decode of Funct[4:1]:
    - 0100 ADD
    - 0010 SUB
    - 0000 AND
    - 1100 ORR
    - 1101 MOV (ADD with ALUSrcA=10)
    - 1010 CMP (SUB, NoWrite)
    - 1000 TST (AND, NoWrite)
    - other: ADD, NoWrite
  - ALUSrcA=00 except MOV.
  - If S=Funct[0]=1: capture N,Z at the end of this cycle. Also capture C,V only for ADD/SUB/CMP.
  - Next state: ALUWB.
- ALUWB:
  - Drive ResultSrc=00, RegWrite = ~NoWrite.
  - PCWrite = ~NoWrite & (Rd==15).
  - Next state: FETCH.
- BRANCH:
  - Drive ALUSrcA=01 (PC+4 held as PC+8 base), ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1.
  - Next state: FETCH.
- Default drive for every unlisted output in a state is 0.

## Timing
- Reset (reset=0):
  - State=FETCH and Flags=0000 immediately (asynchronous).
  - PCWrite, IRWrite, MemWrite, RegWrite are forced to 0 while reset=0.
  - Fetch begins on the first rising edge after release.
- Zero-wait cycle counts:
  - Data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - Squashed instruction: 2
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs are stable during the stall.
- Flags change only at the clock edge ending EXECUTER/EXECUTEI. DECODE of the next instruction sees the new value.
- Reset asserted mid-instruction: the instruction is aborted and write strobes drop combinationally.

## Test plan
- Reset, MemReady=1, Instr=E2802005 (ADD R2,R0,#5):
  - State sequence 0,1,7,8,0.
  - IRWrite=1 in cycle 0 only; RegWrite=1 in ALUWB only.
  - Flags stay 0000.
- E1510001 (CMP R1,R1) with ALUFlags=0110 in EXECUTER:
  - RegWrite=0 throughout; Flags=0110 afterwards.
  - Then 0A000002 (BEQ): states 0,1,9 with PCWrite=1.
  - Then 1A000002 (BNE): states 0,1,0 with no PCWrite.
- E5902060 (LDR) with MemReady=0 for 2 cycles in MEMREAD:
  - Sequence 0,1,2,3,3,3,4.
  - AdrSrc=1 through all MEMREAD cycles; RegWrite=1 in MEMWB.
- E5802064 (STR), MemReady=0 for 1 cycle:
  - MemWrite=1 for 2 cycles, RegWrite=0.
  - With Z=1, 15802064 (STRNE) gives MemWrite never asserted, sequence 0,1,0.
- E1A0300A (MOV R3,R10): ALUSrcA=10, ALUSrcB=00 in EXECUTER. E3B0000F (MOVS R0,#15) with ALUFlags=1011: C,V unchanged, N,Z=10.
- Reset low during MEMWRITE with MemReady=0: MemWrite drops to 0 immediately, State=0, Flags=0000.
